// File: rtl/operand_regfile_pkg.sv
// Shared types and helpers for the operand register file.
//   state_e      : init-sweep FSM states
//   INIT_ZERO    : sweep fills every entry with zero
//   INIT_INDEX   : sweep fills entry i with i
//   init_pattern : value the sweep writes into a given entry
package operand_regfile_pkg;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Returned 32 bits wide; the caller truncates or zero-extends to DATA_W.
  function automatic logic [31:0] init_pattern(input logic [31:0] index, input int mode);
    return (mode == INIT_INDEX) ? index : 32'd0;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init-sweep sequencer for operand_regfile.
// Owns the INIT/READY FSM and the sweep counter. While in INIT it writes
// one entry per cycle, from 0 up to DEPTH-1, then drops to READY.
//   clk, rst_n : clock, asynchronous active-low reset
//   init_req   : single-cycle request for a new sweep (honoured in READY only)
//   busy       : high for the whole sweep
//   init_we    : sweep write enable for the array
//   init_addr  : sweep write address
//   init_data  : sweep write data
module regfile_init_seq
  import operand_regfile_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int INIT_MODE = INIT_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign busy      = (state == ST_INIT);
  assign init_addr = cnt;
  assign init_data = DATA_W'(init_pattern(32'(cnt), INIT_MODE));

endmodule

// File: rtl/operand_regfile.sv
// Operand register file: DEPTH x DATA_W, two registered read ports, one
// write port, hardware init sweep after reset or on init_req.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rd0_en/addr/data/valid: read port 0 (src1), one-cycle latency
//   rd1_en/addr/data/valid: read port 1 (src2), one-cycle latency
//   wr_en/addr/data       : write port from writeback
//   init_req              : start a re-initialisation sweep
//   busy                  : sweep in progress; all accesses ignored
// Addresses at or above DEPTH read as zero and never write.
module operand_regfile
  import operand_regfile_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 8,
  parameter  int INIT_MODE = INIT_ZERO,
  parameter  int BYPASS    = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init_req,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  logic              access_ok;
  logic              usr_we;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] rd0_word_p0, rd1_word_p0;
  logic              rd0_acc_p0, rd1_acc_p0;

  regfile_init_seq #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_MODE (INIT_MODE)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // A cycle carrying init_req drops its reads and writes as well.
  assign access_ok = !busy && !init_req;
  assign usr_we    = access_ok && wr_en && ({1'b0, wr_addr} < DEPTH_C);

  always_comb begin
    if (busy) begin
      arr_we    = init_we;
      arr_addr  = init_addr;
      arr_wdata = init_data;
    end else begin
      arr_we    = usr_we;
      arr_addr  = wr_addr;
      arr_wdata = wr_data;
    end
  end

  // Storage is deliberately unreset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (arr_we) mem[arr_addr] <= arr_wdata;
  end

  // Range check wins over bypass so an out-of-range collision still reads 0.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
    if ({1'b0, addr} >= DEPTH_C) return '0;
    if ((BYPASS != 0) && usr_we && (wr_addr == addr)) return wr_data;
    return mem[addr];
  endfunction

  // ---- p0: address decode / bypass select ----
  always_comb begin
    rd0_acc_p0  = access_ok && rd0_en;
    rd1_acc_p0  = access_ok && rd1_en;
    rd0_word_p0 = read_word(rd0_addr);
    rd1_word_p0 = read_word(rd1_addr);
  end

  // ---- p1: registered read outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_data  <= '0;
      rd0_valid <= 1'b0;
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd0_valid <= rd0_acc_p0;
      rd1_valid <= rd1_acc_p0;
      if (rd0_acc_p0) rd0_data <= rd0_word_p0;
      if (rd1_acc_p0) rd1_data <= rd1_word_p0;
    end
  end

endmodule

// File: tb/tb_operand_regfile.sv
module tb_operand_regfile;

  localparam int N = 3;  // 0: D8/idx/bypass  1: D8/idx/no-bypass  2: D6/zero/bypass

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd0_en, rd1_en, wr_en, init_req;
  logic [2:0] rd0_addr, rd1_addr, wr_addr;
  logic [7:0] wr_data;

  logic [N-1:0][7:0] o_d0, o_d1;
  logic [N-1:0]      o_v0, o_v1, o_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_regfile #(.DATA_W(8), .DEPTH(8), .INIT_MODE(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(o_d0[0]), .rd0_valid(o_v0[0]),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(o_d1[0]), .rd1_valid(o_v1[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_req(init_req), .busy(o_busy[0]));

  operand_regfile #(.DATA_W(8), .DEPTH(8), .INIT_MODE(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(o_d0[1]), .rd0_valid(o_v0[1]),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(o_d1[1]), .rd1_valid(o_v1[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_req(init_req), .busy(o_busy[1]));

  operand_regfile #(.DATA_W(8), .DEPTH(6), .INIT_MODE(0), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(o_d0[2]), .rd0_valid(o_v0[2]),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(o_d1[2]), .rd1_valid(o_v1[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_req(init_req), .busy(o_busy[2]));

  // ---------------- reference model ----------------
  function automatic int dep_of(int k);  return (k == 2) ? 6 : 8; endfunction
  function automatic int mode_of(int k); return (k == 2) ? 0 : 1; endfunction
  function automatic int byp_of(int k);  return (k == 1) ? 0 : 1; endfunction

  int         m_busy [N];       // sweep cycles still to go
  logic [7:0] m_mem  [N][8];
  logic [7:0] m_d0   [N];
  logic [7:0] m_d1   [N];
  logic       m_v0   [N];
  logic       m_v1   [N];

  function automatic logic [7:0] model_read(int k, logic [2:0] a);
    if (int'(a) >= dep_of(k)) return 8'h00;
    if (byp_of(k) == 1 && wr_en && wr_addr == a) return wr_data;
    return m_mem[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = dep_of(k);
      m_d0[k] = 8'h00; m_d1[k] = 8'h00;
      m_v0[k] = 1'b0;  m_v1[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      int d = dep_of(k);
      if (!rst_n) continue;
      if (m_busy[k] > 0) begin
        m_mem[k][d - m_busy[k]] = (mode_of(k) == 1) ? 8'(d - m_busy[k]) : 8'h00;
        m_busy[k]--;
        m_v0[k] = 1'b0; m_v1[k] = 1'b0;
      end else if (init_req) begin
        m_busy[k] = d;
        m_v0[k] = 1'b0; m_v1[k] = 1'b0;
      end else begin
        logic [7:0] r0, r1;
        r0 = model_read(k, rd0_addr);
        r1 = model_read(k, rd1_addr);
        m_v0[k] = rd0_en; m_v1[k] = rd1_en;
        if (rd0_en) m_d0[k] = r0;
        if (rd1_en) m_d1[k] = r1;
        if (wr_en && int'(wr_addr) < d) m_mem[k][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd0_en = 0; rd1_en = 0; wr_en = 0; init_req = 0;
    rd0_addr = 0; rd1_addr = 0; wr_addr = 0; wr_data = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_busy[k] !== 1'b1 || o_v0[k] !== 1'b0 || o_v1[k] !== 1'b0 ||
          o_d0[k] !== 8'h00 || o_d1[k] !== 8'h00) begin
        failures++;
        $display("FAIL reset_state dut%0d: busy=%b v0=%b v1=%b d0=%h d1=%h required busy=1 v=0 d=00",
                 k, o_busy[k], o_v0[k], o_v1[k], o_d0[k], o_d1[k]);
      end
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (o_busy[0] !== (i < 8)) begin
        failures++;
        $display("FAIL busy_len cycle%0d: busy=%b required %b", i, o_busy[0], (i < 8));
      end
      checks++;
      if (o_busy[2] !== (i < 6)) begin
        failures++;
        $display("FAIL busy_len_d6 cycle%0d: busy=%b required %b", i, o_busy[2], (i < 6));
      end
    end
  endtask

  task automatic test_init_read();
    for (int i = 0; i < 8; i++) begin
      rd0_en = 1; rd0_addr = 3'(i);
      rd1_en = 1; rd1_addr = 3'(7 - i);
      tick();
      checks++;
      if (o_d0[0] !== 8'(i) || o_v0[0] !== 1'b1 || o_d1[0] !== 8'(7 - i) || o_v1[0] !== 1'b1) begin
        failures++;
        $display("FAIL init_read addr%0d: d0=%h v0=%b d1=%h v1=%b required d0=%h d1=%h v=1",
                 i, o_d0[0], o_v0[0], o_d1[0], o_v1[0], 8'(i), 8'(7 - i));
      end
      checks++;
      if (o_d0[2] !== 8'h00 || o_v0[2] !== 1'b1) begin
        failures++;
        $display("FAIL init_read_d6 addr%0d: d0=%h v0=%b required 00/1", i, o_d0[2], o_v0[2]);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (o_v0[0] !== 1'b0 || o_v1[0] !== 1'b0 || o_d0[0] !== 8'h07 || o_d1[0] !== 8'h00) begin
      failures++;
      $display("FAIL read_hold: v0=%b v1=%b d0=%h d1=%h required v=0 d0=07 d1=00",
               o_v0[0], o_v1[0], o_d0[0], o_d1[0]);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 3; wr_data = 8'hA5;
    tick();
    idle_inputs();
    rd0_en = 1; rd0_addr = 3; rd1_en = 1; rd1_addr = 3;
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_d0[k] !== 8'hA5 || o_d1[k] !== 8'hA5 || o_v0[k] !== 1'b1 || o_v1[k] !== 1'b1) begin
        failures++;
        $display("FAIL write_read dut%0d: d0=%h d1=%h v0=%b v1=%b required A5 A5 1 1",
                 k, o_d0[k], o_d1[k], o_v0[k], o_v1[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    logic [7:0] req [N];
    req[0] = 8'h3C; req[1] = 8'h05; req[2] = 8'h3C;
    wr_en = 1; wr_addr = 5; wr_data = 8'h3C;
    rd0_en = 1; rd0_addr = 5;
    tick();
    idle_inputs();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_d0[k] !== req[k] || o_v0[k] !== 1'b1) begin
        failures++;
        $display("FAIL collision dut%0d: d0=%h v0=%b required %h/1", k, o_d0[k], o_v0[k], req[k]);
      end
    end
    rd0_en = 1; rd0_addr = 5;
    tick();
    idle_inputs();
    checks++;
    if (o_d0[1] !== 8'h3C) begin
      failures++;
      $display("FAIL collision_after_nobyp: d0=%h required 3C", o_d0[1]);
    end
  endtask

  task automatic test_out_of_range();
    wr_en = 1; wr_addr = 6; wr_data = 8'h77;
    tick();
    idle_inputs();
    rd0_en = 1; rd0_addr = 6;
    tick();
    checks++;
    if (o_d0[2] !== 8'h00 || o_v0[2] !== 1'b1) begin
      failures++;
      $display("FAIL oor_read_d6: d0=%h v0=%b required 00/1", o_d0[2], o_v0[2]);
    end
    checks++;
    if (o_d0[0] !== 8'h77) begin
      failures++;
      $display("FAIL inrange_addr6_d8: d0=%h required 77", o_d0[0]);
    end
    for (int i = 0; i < 6; i++) begin
      rd0_en = 1; rd0_addr = 3'(i);
      tick();
      checks++;
      if (o_d0[2] !== m_d0[2] || o_v0[2] !== 1'b1) begin
        failures++;
        $display("FAIL oor_no_alias_d6 addr%0d: d0=%h v0=%b required %h/1", i, o_d0[2], o_v0[2], m_d0[2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_init_req();
    int budget;
    wr_en = 1; wr_addr = 2; wr_data = 8'hFF;
    tick();
    idle_inputs();
    init_req = 1; rd0_en = 1; rd0_addr = 2; wr_en = 1; wr_addr = 4; wr_data = 8'hEE;
    tick();
    init_req = 0; wr_en = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (o_busy[2] !== 1'b1 || o_v0[2] !== 1'b0) begin
        failures++;
        $display("FAIL init_req_busy cycle%0d: busy=%b v0=%b required 1/0", i, o_busy[2], o_v0[2]);
      end
      tick();
    end
    budget = 20;
    while (o_busy != '0 && budget > 0) begin tick(); budget--; end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL init_req_timeout: busy=%b required 000", o_busy);
    end
    rd0_en = 1; rd0_addr = 2; rd1_en = 1; rd1_addr = 4;
    tick();
    idle_inputs();
    checks++;
    if (o_d0[2] !== 8'h00 || o_v0[2] !== 1'b1 || o_d0[0] !== 8'h02 || o_d1[0] !== 8'h04) begin
      failures++;
      $display("FAIL after_reinit: c.d0=%h c.v0=%b a.d0=%h a.d1=%h required 00 1 02 04",
               o_d0[2], o_v0[2], o_d0[0], o_d1[0]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    init_req = 1;
    tick();
    init_req = 0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_busy[k] !== 1'b1 || o_v0[k] !== 1'b0 || o_d0[k] !== 8'h00 || o_d1[k] !== 8'h00) begin
        failures++;
        $display("FAIL mid_sweep_reset dut%0d: busy=%b v0=%b d0=%h d1=%h required 1 0 00 00",
                 k, o_busy[k], o_v0[k], o_d0[k], o_d1[k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (o_busy[0] !== (i < 8)) begin
        failures++;
        $display("FAIL resweep_len cycle%0d: busy=%b required %b", i, o_busy[0], (i < 8));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rd0_en   = 1'($urandom_range(0, 1));
      rd1_en   = 1'($urandom_range(0, 1));
      wr_en    = 1'($urandom_range(0, 1));
      rd0_addr = 3'($urandom_range(0, 7));
      rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      init_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) rd0_addr = wr_addr;
      tick();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (o_d0[k] !== m_d0[k] || o_v0[k] !== m_v0[k] || o_d1[k] !== m_d1[k] ||
            o_v1[k] !== m_v1[k] || o_busy[k] !== (m_busy[k] > 0)) begin
          failures++;
          $display("FAIL random c%0d dut%0d: d0=%h v0=%b d1=%h v1=%b busy=%b required %h %b %h %b %b",
                   c, k, o_d0[k], o_v0[k], o_d1[k], o_v1[k], o_busy[k],
                   m_d0[k], m_v0[k], m_d1[k], m_v1[k], (m_busy[k] > 0));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_init_req();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Parametrised successor to the single-port operand ROM: a DEPTH x DATA_W operand register file with two synchronous read ports and one write port.
- Adds a hardware init sweep after reset or on request, optional write-to-read bypass, and a read-valid flag.
- Sits between the instruction decoder (read addresses) and the ALU (src1/src2 operands); the writeback stage drives the write port.

Parameters:
DATA_W, 8, operand width in bits
DEPTH, 8, number of entries; DEPTH >= 2, not required to be a power of two
ADDR_W, $clog2(DEPTH), address width; derived, not overridden
INIT_MODE, 0, init-sweep pattern: 0 = all zero, 1 = entry i holds i (truncated/zero-extended to DATA_W)
BYPASS, 1, 1 = same-cycle write is forwarded to a matching read; 0 = read returns the pre-write value

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
rd0_en  in  1  read request, port 0 (src1)
rd0_addr  in  ADDR_W  read address, port 0
rd0_data  out  DATA_W  read data, port 0, registered
rd0_valid  out  1  rd0_data holds the result of the previous cycle's accepted request
rd1_en  in  1  read request, port 1 (src2)
rd1_addr  in  ADDR_W  read address, port 1
rd1_data  out  DATA_W  read data, port 1, registered
rd1_valid  out  1  as rd0_valid, for port 1
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
init_req  in  1  single-cycle pulse; starts a re-initialisation sweep
busy  out  1  high while the init sweep runs; all accesses are ignored

Behaviour:
- Reset (rst_n low, asynchronous): FSM = INIT, sweep counter = 0, busy = 1, rd0/rd1_data = 0, rd0/rd1_valid = 0. The storage array is not reset; the sweep initialises it.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes the pattern into entry[counter], then increments the counter.
  - After entry DEPTH-1 is written (exactly DEPTH cycles after rst_n deasserts), moves to READY; busy falls on that same edge.
  - rdN_valid = 0 and rdN_data hold their values.
  - wr_en is dropped; init_req is ignored.
- READY:
  - init_req = 1 -> INIT with counter = 0 and busy = 1 on the next edge. A read or write presented in the same cycle is dropped.
- Read (READY, rdN_en = 1): rdN_data = entry[rdN_addr] and rdN_valid = 1 on the next edge; latency 1 cycle.
- rdN_en = 0: rdN_valid = 0 next cycle; rdN_data holds its previous value.
- Write (READY, wr_en = 1): entry[wr_addr] = wr_data at the edge.
- Read/write collision (same cycle, wr_addr == rdN_addr):
  - BYPASS = 1: rdN_data = wr_data.
  - BYPASS = 0: rdN_data = old contents.
  - Applies to each port independently; both ports may read the same address.
- Out-of-range address (addr >= DEPTH, possible only when DEPTH is not a power of two):
  - Read returns 0 with valid = 1.
  - Write is dropped; no aliasing.
- Reset asserted mid-sweep or mid-access: immediate return to reset values; the sweep restarts from entry 0 after release.

Decomposition:
- Package operand_regfile_pkg:
  - FSM state enum (ST_INIT, ST_READY).
  - INIT_MODE constants (INIT_ZERO = 0, INIT_INDEX = 1).
  - Function init_pattern(index, mode).
- One sub-module, regfile_init_seq: owns the FSM, sweep counter and busy. Outputs the sweep write enable, address and data, which are muxed onto the array write port.
- Top level contains the array, read registers and bypass compare.

Test Plan:
- Reset, INIT_MODE = 1, DEPTH = 8 -> busy = 1 for exactly 8 cycles after rst_n rises. Then reads of addresses 0..7 return 0..7 with valid = 1, one cycle after each request.
- Write 8'hA5 to address 3, then next cycle read address 3 on both ports -> rd0_data = rd1_data = 8'hA5, both valid.
- Same-cycle collision: write 8'h3C to address 5 while rd0 reads 5.
  - BYPASS = 1 -> rd0_data = 8'h3C.
  - BYPASS = 0 -> rd0_data = 8'h05 (INIT_MODE = 1).
- init_req in READY after writing 8'hFF to address 2 -> busy high for DEPTH cycles and reads ignored (valid = 0). Afterwards, address 2 reads 0 (INIT_MODE = 0).
- DEPTH = 6: write 8'h77 to address 6, read address 6 -> rd data = 0, valid = 1. Entries 0..5 are unchanged.
- Assert rst_n low on sweep cycle 4 -> outputs return to reset values immediately. After release, busy stays high for a full DEPTH cycles.
